// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and select encoding helper for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int unsigned N_REQ_DEF    = 8;
    localparam int unsigned SEL_W_DEF    = 3;
    localparam int unsigned MAX_HOLD_DEF = 4;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Binary to reflected Gray: g[2]=b[2], g[1]=b[2]^b[1], g[0]=b[1]^b[0].
    function automatic logic [SEL_W_DEF-1:0] bin2gray(input logic [SEL_W_DEF-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, wrapping.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any_req,
    output logic [SEL_W-1:0] winner
);

    // Scan ptr, ptr+1, ... and keep the first hit; index arithmetic wraps at SEL_W bits.
    always_comb begin
        logic [SEL_W-1:0] idx;
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = ptr + SEL_W'(i);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 8:1 one-bit mux between requesters, with valid/ready output.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    input  logic             out_ready,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] muxsel,
    output logic [SEL_W-1:0] muxsel_gray,
    output logic             out_data,
    output logic             out_valid,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   muxsel_q, muxsel_d;
    logic [SEL_W-1:0]   gray_q, gray_d;
    logic               valid_q, valid_d;

    logic               any_req;
    logic [SEL_W-1:0]   winner;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;
    logic               release_grant;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any_req (any_req),
        .winner  (winner)
    );

    assign xfer          = valid_q & out_ready;
    assign cnt_inc       = cnt_q + CNT_W'(1);
    // A transfer coinciding with a request drop is counted first; release happens either way.
    assign release_grant = (xfer && (cnt_inc == CNT_W'(MAX_HOLD))) || !req[muxsel_q];

    // Next-state: arbitrate in IDLE, count transfers and release in GRANT.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        muxsel_d = muxsel_q;
        gray_d   = gray_q;
        valid_d  = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_GRANT;
                    muxsel_d = winner;
                    gray_d   = bin2gray(winner);
                    grant_d  = N_REQ'(1) << winner;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                end
                if (release_grant) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    // muxsel/gray are left holding the last winner through IDLE.
                    ptr_d   = muxsel_q + SEL_W'(1);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            muxsel_q <= '0;
            gray_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            muxsel_q <= muxsel_d;
            gray_q   <= gray_d;
            valid_q  <= valid_d;
        end
    end

    assign grant       = grant_q;
    assign muxsel      = muxsel_q;
    assign muxsel_gray = gray_q;
    assign out_valid   = valid_q;
    assign busy        = (state_q == ST_GRANT);
    assign out_data    = data_in[muxsel_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] data_in;
    logic       out_ready;
    logic [7:0] grant;
    logic [2:0] muxsel;
    logic [2:0] muxsel_gray;
    logic       out_data;
    logic       out_valid;
    logic       busy;

    int vec_cnt;
    int err_cnt;

    logic [2:0] gray_tbl [8];
    logic [7:0] pattern;

    rr_mux_arbiter u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .out_ready   (out_ready),
        .grant       (grant),
        .muxsel      (muxsel),
        .muxsel_gray (muxsel_gray),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input int k);
        chk({tag, ".grant"}, 32'(grant), 32'(8'h01 << k));
        chk({tag, ".muxsel"}, 32'(muxsel), 32'(k));
        chk({tag, ".gray"}, 32'(muxsel_gray), 32'(gray_tbl[k]));
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        gray_tbl = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        rst = 1'b1;
        req = 8'hFF;
        data_in = 8'h00;
        out_ready = 1'b0;

        // Reset state with all requests held.
        tick();
        tick();
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.muxsel", 32'(muxsel), 32'h0);
        chk("rst.gray", 32'(muxsel_gray), 32'h0);

        // First grant one cycle after reset release.
        rst = 1'b0;
        tick();
        chk_grant("first", 0);

        // Full rotation with out_ready high: 4 transfers per grant, one bubble between grants.
        out_ready = 1'b1;
        pattern = 8'hA5;
        data_in = pattern;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                #0;
                chk_grant($sformatf("rot%0d.%0d", k, j), k);
                chk($sformatf("rot%0d.%0d.data", k, j), 32'(out_data), 32'(pattern[k]));
                tick();
            end
            chk($sformatf("bub%0d.valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("bub%0d.grant", k), 32'(grant), 32'd0);
            chk($sformatf("bub%0d.busy", k), 32'(busy), 32'd0);
            chk($sformatf("bub%0d.hold", k), 32'(muxsel_gray), 32'(gray_tbl[k]));
            tick();
        end
        chk_grant("rot_wrap", 0);

        // Wrap: serve 2, then 7 from ptr=3, then back to 2 after wrapping to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'b1000_0100;
        tick();
        chk_grant("wrap.a", 2);
        repeat (4) tick();
        chk("wrap.rel", 32'(out_valid), 32'd0);
        chk("wrap.ptr3", 32'(u_dut.ptr_q), 32'd3);
        tick();
        chk_grant("wrap.b", 7);
        repeat (4) tick();
        chk("wrap.ptr0", 32'(u_dut.ptr_q), 32'd0);
        tick();
        chk_grant("wrap.c", 2);

        // Early release: requester 5, two transfers, then drop request with out_ready low.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h20;
        out_ready = 1'b1;
        tick();
        chk_grant("early", 5);
        tick();
        tick();
        chk("early.cnt2", 32'(u_dut.cnt_q), 32'd2);
        chk("early.still", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        req = 8'h00;
        tick();
        chk("early.valid", 32'(out_valid), 32'd0);
        chk("early.grant", 32'(grant), 32'd0);
        chk("early.ptr", 32'(u_dut.ptr_q), 32'd6);
        chk("early.cnt", 32'(u_dut.cnt_q), 32'd0);

        // Backpressure on requester 3: grant holds, cnt stays 0, out_data follows data_in[3].
        req = 8'h08;
        tick();
        chk_grant("bp", 3);
        for (int c = 0; c < 10; c++) begin
            pattern = (c % 2 == 0) ? 8'h08 : 8'hF7;
            data_in = pattern;
            #1;
            chk($sformatf("bp%0d.grant", c), 32'(grant), 32'h08);
            chk($sformatf("bp%0d.data", c), 32'(out_data), 32'(pattern[3]));
            chk($sformatf("bp%0d.cnt", c), 32'(u_dut.cnt_q), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bp.x3.valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp.x4.valid", 32'(out_valid), 32'd0);
        chk("bp.x4.ptr", 32'(u_dut.ptr_q), 32'd4);

        // Reset mid-grant at cnt=2.
        req = 8'hFF;
        tick();
        chk_grant("mid", 4);
        tick();
        tick();
        chk("mid.cnt2", 32'(u_dut.cnt_q), 32'd2);
        rst = 1'b1;
        tick();
        chk("mid.grant", 32'(grant), 32'd0);
        chk("mid.valid", 32'(out_valid), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.muxsel", 32'(muxsel), 32'd0);
        chk("mid.gray", 32'(muxsel_gray), 32'd0);
        chk("mid.ptr", 32'(u_dut.ptr_q), 32'd0);
        chk("mid.cnt", 32'(u_dut.cnt_q), 32'd0);
        rst = 1'b0;
        tick();
        chk_grant("mid.after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
